pll_dyn_ctrl: RTL and testbench

Parametrised PLL control block for the GTP_PLL_E1-based clock generators. It drives the primitive's RST and dynamic RATIO/DUTY inputs, sequences reset and lock acquisition, qualifies LOCK as stable, and re-locks automatically on lock loss. It also accepts run-time divider reconfiguration through a valid/ready handshake. It sits between the board reference clock and the PLL primitive instance, and replaces fixed-ratio wrappers wherever dynamic ratios are enabled.

---
 rtl/pll_ctrl_pkg.sv | 21 ++
 rtl/pll_lock_sync.sv | 25 ++
 rtl/pll_dyn_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_pll_dyn_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types and helpers for the PLL control blocks.
package pll_ctrl_pkg;

   // Width of every ratio field on the GTP_PLL_E1 dynamic interface.
   localparam int RATIO_W = 10;

   // Controller states.
   typedef enum logic [2:0] {
      ST_RESET_HOLD = 3'd0,
      ST_WAIT_LOCK  = 3'd1,
      ST_STABLE     = 3'd2,
      ST_LOCKED     = 3'd3,
      ST_FAILED     = 3'd4
   } pll_state_e;

   // A 50 % duty cycle is obtained by programming DUTYn equal to RATIOn.
   function automatic logic [RATIO_W-1:0] duty_from_ratio(input logic [RATIO_W-1:0] i_ratio);
      return i_ratio;
   endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer with asynchronous clear, used for the PLL LOCK input.
module pll_lock_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_async,
   output logic o_sync
);

   logic r_meta;
   logic r_sync;

   // Resample the asynchronous input twice; cleared to "not locked".
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

// File: rtl/pll_dyn_ctrl.sv
// PLL reset/lock sequencer with run-time ratio reconfiguration for GTP_PLL_E1.
module pll_dyn_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int                         NUM_OUT            = 5,
   parameter int                         RATIO_MAX          = 128,
   parameter int                         DEF_IDIV           = 2,
   parameter int                         DEF_FDIV           = 24,
   parameter logic [NUM_OUT*RATIO_W-1:0] DEF_ODIV           = {NUM_OUT{10'd6}},
   parameter int                         RST_HOLD_CYCLES    = 16,
   parameter int                         LOCK_TIMEOUT       = 65535,
   parameter int                         LOCK_STABLE_CYCLES = 256,
   parameter int                         MAX_RETRIES        = 3
) (
   input  logic                         clkin1,
   input  logic                         pll_rst,
   input  logic                         lock_raw,
   input  logic                         cfg_valid,
   output logic                         cfg_ready,
   input  logic [RATIO_W-1:0]           cfg_idiv,
   input  logic [RATIO_W-1:0]           cfg_fdiv,
   input  logic [NUM_OUT*RATIO_W-1:0]   cfg_odiv,
   output logic                         cfg_err,
   output logic                         prim_rst,
   output logic [RATIO_W-1:0]           dyn_idiv,
   output logic [RATIO_W-1:0]           dyn_fdiv,
   output logic [NUM_OUT*RATIO_W-1:0]   dyn_odiv,
   output logic [NUM_OUT*RATIO_W-1:0]   dyn_duty,
   output logic                         pll_lock,
   output logic                         busy,
   output logic                         fail,
   output logic [7:0]                   lock_lost_cnt
);

   localparam int ODIV_W = NUM_OUT*RATIO_W;
   localparam int HOLD_W = $clog2(RST_HOLD_CYCLES+1);
   localparam int TMO_W  = $clog2(LOCK_TIMEOUT+1);
   localparam int STB_W  = $clog2(LOCK_STABLE_CYCLES+1);
   localparam int RTY_W  = $clog2(MAX_RETRIES+1);

   pll_state_e          r_state;
   pll_state_e          w_state_nxt;
   logic [HOLD_W-1:0]   r_hold_cnt;
   logic [TMO_W-1:0]    r_tmo_cnt;
   logic [STB_W-1:0]    r_stb_cnt;
   logic [RTY_W-1:0]    r_retry_cnt;
   logic [7:0]          r_lost_cnt;
   logic                r_cfg_err;
   logic [RATIO_W-1:0]  r_dyn_idiv;
   logic [RATIO_W-1:0]  r_dyn_fdiv;
   logic [ODIV_W-1:0]   r_dyn_odiv;
   logic                w_lock_s;
   logic                w_cfg_ok;
   logic                w_cfg_take;
   logic                w_timeout;
   logic                w_prim_rst;
   logic                w_pll_lock;
   logic                w_cfg_ready;
   logic                w_busy;
   logic                w_fail;

   // A ratio field is legal when it lies in 1..RATIO_MAX.
   function automatic logic ratio_ok(input logic [RATIO_W-1:0] i_val);
      return (i_val != {RATIO_W{1'b0}}) && (i_val <= RATIO_W'(RATIO_MAX));
   endfunction

   pll_lock_sync u_lock_sync (
      .i_clk   (clkin1),
      .i_rst   (pll_rst),
      .i_async (lock_raw),
      .o_sync  (w_lock_s)
   );

   // Validate every field of the offered ratio set.
   always_comb begin
      w_cfg_ok = ratio_ok(cfg_idiv) & ratio_ok(cfg_fdiv);
      for (int i = 0; i < NUM_OUT; i++) begin
         w_cfg_ok = w_cfg_ok & ratio_ok(cfg_odiv[i*RATIO_W +: RATIO_W]);
      end
   end

   assign w_cfg_take = cfg_valid & w_cfg_ready & w_cfg_ok;

   // State register.
   always_ff @(posedge clkin1 or posedge pll_rst) begin
      if (pll_rst) begin
         r_state <= ST_RESET_HOLD;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; an accepted configuration overrides everything else.
   always_comb begin
      w_state_nxt = r_state;
      w_timeout   = 1'b0;
      if (w_cfg_take) begin
         w_state_nxt = ST_RESET_HOLD;
      end else begin
         case (r_state)
            ST_RESET_HOLD: begin
               if (r_hold_cnt == HOLD_W'(RST_HOLD_CYCLES-1)) begin
                  w_state_nxt = ST_WAIT_LOCK;
               end else begin
                  w_state_nxt = ST_RESET_HOLD;
               end
            end
            ST_WAIT_LOCK: begin
               if (w_lock_s) begin
                  w_state_nxt = ST_STABLE;
               end else if (r_tmo_cnt == TMO_W'(LOCK_TIMEOUT-1)) begin
                  w_timeout = 1'b1;
                  if (r_retry_cnt + RTY_W'(1) == RTY_W'(MAX_RETRIES)) begin
                     w_state_nxt = ST_FAILED;
                  end else begin
                     w_state_nxt = ST_RESET_HOLD;
                  end
               end else begin
                  w_state_nxt = ST_WAIT_LOCK;
               end
            end
            ST_STABLE: begin
               if (!w_lock_s) begin
                  w_state_nxt = ST_WAIT_LOCK;
               end else if (r_stb_cnt == STB_W'(LOCK_STABLE_CYCLES-1)) begin
                  w_state_nxt = ST_LOCKED;
               end else begin
                  w_state_nxt = ST_STABLE;
               end
            end
            ST_LOCKED: begin
               if (!w_lock_s) begin
                  w_state_nxt = ST_RESET_HOLD;
               end else begin
                  w_state_nxt = ST_LOCKED;
               end
            end
            ST_FAILED:  w_state_nxt = ST_FAILED;
            default:    w_state_nxt = ST_RESET_HOLD;
         endcase
      end
   end

   // Output decode from the registered state.
   always_comb begin
      w_prim_rst  = 1'b0;
      w_pll_lock  = 1'b0;
      w_cfg_ready = 1'b0;
      w_busy      = 1'b1;
      w_fail      = 1'b0;
      case (r_state)
         ST_RESET_HOLD: w_prim_rst = 1'b1;
         ST_WAIT_LOCK:  w_prim_rst = 1'b0;
         ST_STABLE:     w_prim_rst = 1'b0;
         ST_LOCKED: begin
            w_pll_lock  = 1'b1;
            w_cfg_ready = 1'b1;
            w_busy      = 1'b0;
         end
         ST_FAILED: begin
            w_prim_rst  = 1'b1;
            w_fail      = 1'b1;
            w_cfg_ready = 1'b1;
            w_busy      = 1'b0;
         end
         default:       w_prim_rst = 1'b1;
      endcase
   end

   // Hold, timeout and stability counters. The timeout counter is only cleared
   // by a reset pulse so that lock bouncing in STABLE cannot extend an attempt;
   // the stability counter includes the edge on which lock was first seen.
   always_ff @(posedge clkin1 or posedge pll_rst) begin
      if (pll_rst) begin
         r_hold_cnt <= {HOLD_W{1'b0}};
         r_tmo_cnt  <= {TMO_W{1'b0}};
         r_stb_cnt  <= {STB_W{1'b0}};
      end else begin
         if (r_state == ST_RESET_HOLD && w_state_nxt == ST_RESET_HOLD) begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
         end else begin
            r_hold_cnt <= {HOLD_W{1'b0}};
         end
         if (r_state == ST_RESET_HOLD) begin
            r_tmo_cnt <= {TMO_W{1'b0}};
         end else if (r_state == ST_WAIT_LOCK && w_state_nxt == ST_WAIT_LOCK) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
         end else begin
            r_tmo_cnt <= r_tmo_cnt;
         end
         if (w_state_nxt == ST_STABLE && r_state == ST_STABLE) begin
            r_stb_cnt <= r_stb_cnt + STB_W'(1);
         end else if (w_state_nxt == ST_STABLE) begin
            r_stb_cnt <= STB_W'(1);
         end else begin
            r_stb_cnt <= {STB_W{1'b0}};
         end
      end
   end

   // Retry and lock-loss bookkeeping.
   always_ff @(posedge clkin1 or posedge pll_rst) begin
      if (pll_rst) begin
         r_retry_cnt <= {RTY_W{1'b0}};
         r_lost_cnt  <= 8'd0;
      end else begin
         if (w_cfg_take || (r_state == ST_STABLE && w_state_nxt == ST_LOCKED)) begin
            r_retry_cnt <= {RTY_W{1'b0}};
         end else if (w_timeout) begin
            r_retry_cnt <= r_retry_cnt + RTY_W'(1);
         end else begin
            r_retry_cnt <= r_retry_cnt;
         end
         if (r_state == ST_LOCKED && !w_lock_s && r_lost_cnt != 8'hFF) begin
            r_lost_cnt <= r_lost_cnt + 8'd1;
         end else begin
            r_lost_cnt <= r_lost_cnt;
         end
      end
   end

   // Ratio registers and the reject pulse; ratios only move on an accept edge.
   always_ff @(posedge clkin1 or posedge pll_rst) begin
      if (pll_rst) begin
         r_dyn_idiv <= RATIO_W'(DEF_IDIV);
         r_dyn_fdiv <= RATIO_W'(DEF_FDIV);
         r_dyn_odiv <= DEF_ODIV;
         r_cfg_err  <= 1'b0;
      end else begin
         r_cfg_err <= cfg_valid & w_cfg_ready & ~w_cfg_ok;
         if (w_cfg_take) begin
            r_dyn_idiv <= cfg_idiv;
            r_dyn_fdiv <= cfg_fdiv;
            r_dyn_odiv <= cfg_odiv;
         end else begin
            r_dyn_idiv <= r_dyn_idiv;
            r_dyn_fdiv <= r_dyn_fdiv;
            r_dyn_odiv <= r_dyn_odiv;
         end
      end
   end

   for (genvar g = 0; g < NUM_OUT; g++) begin : g_duty
      assign dyn_duty[g*RATIO_W +: RATIO_W] = duty_from_ratio(r_dyn_odiv[g*RATIO_W +: RATIO_W]);
   end

   assign cfg_ready     = w_cfg_ready;
   assign cfg_err       = r_cfg_err;
   assign prim_rst      = w_prim_rst;
   assign dyn_idiv      = r_dyn_idiv;
   assign dyn_fdiv      = r_dyn_fdiv;
   assign dyn_odiv      = r_dyn_odiv;
   assign pll_lock      = w_pll_lock;
   assign busy          = w_busy;
   assign fail          = w_fail;
   assign lock_lost_cnt = r_lost_cnt;

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Self-checking bench for pll_dyn_ctrl: ratio-set vector table plus lock sequences.
module tb_pll_dyn_ctrl;

   localparam int OW = 50;

   typedef struct packed {
      logic [9:0]    idiv;
      logic [9:0]    fdiv;
      logic [OW-1:0] odiv;
      logic          ok;
   } cfg_vec_t;

   logic          clkin1 = 1'b0;
   logic          pll_rst;
   logic          lock_raw;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [9:0]    cfg_idiv;
   logic [9:0]    cfg_fdiv;
   logic [OW-1:0] cfg_odiv;
   logic          cfg_err;
   logic          prim_rst;
   logic [9:0]    dyn_idiv;
   logic [9:0]    dyn_fdiv;
   logic [OW-1:0] dyn_odiv;
   logic [OW-1:0] dyn_duty;
   logic          pll_lock;
   logic          busy;
   logic          fail;
   logic [7:0]    lock_lost_cnt;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clkin1 = ~clkin1;

   pll_dyn_ctrl #(.NUM_OUT(5), .LOCK_TIMEOUT(100)) dut (
      .clkin1(clkin1), .pll_rst(pll_rst), .lock_raw(lock_raw),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_idiv(cfg_idiv), .cfg_fdiv(cfg_fdiv), .cfg_odiv(cfg_odiv),
      .cfg_err(cfg_err), .prim_rst(prim_rst),
      .dyn_idiv(dyn_idiv), .dyn_fdiv(dyn_fdiv), .dyn_odiv(dyn_odiv), .dyn_duty(dyn_duty),
      .pll_lock(pll_lock), .busy(busy), .fail(fail), .lock_lost_cnt(lock_lost_cnt)
   );

   task automatic cyc();
      @(negedge clkin1);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual %0h required %0h", nm, act, exp);
      end
   endtask

   // Number of sampled cycles prim_rst stays high, starting at the current negedge.
   task automatic count_high(output int n);
      n = 0;
      while (prim_rst === 1'b1 && n < 200) begin
         n++;
         cyc();
      end
   endtask

   task automatic count_low(output int n);
      n = 0;
      while (prim_rst === 1'b0 && n < 500) begin
         n++;
         cyc();
      end
   endtask

   task automatic wait_lock(output int n);
      n = 0;
      while (pll_lock !== 1'b1 && n < 2000) begin
         cyc();
         n++;
      end
   endtask

   task automatic offer(input logic [9:0] i, input logic [9:0] f, input logic [OW-1:0] o);
      cfg_idiv  = i;
      cfg_fdiv  = f;
      cfg_odiv  = o;
      cfg_valid = 1'b1;
      cyc();
      cfg_valid = 1'b0;
   endtask

   initial begin
      int n;
      logic [9:0]    exp_idiv;
      logic [9:0]    exp_fdiv;
      logic [OW-1:0] exp_odiv;
      cfg_vec_t      vecs [7];

      vecs[0] = {10'd1,   10'd30,  {10'd6, 10'd6, 10'd6, 10'd6, 10'd5}, 1'b1};
      vecs[1] = {10'd1,   10'd30,  {10'd6, 10'd6, 10'd6, 10'd6, 10'd0}, 1'b0};
      vecs[2] = {10'd2,   10'd129, {5{10'd6}},                          1'b0};
      vecs[3] = {10'd128, 10'd128, {5{10'd128}},                        1'b1};
      vecs[4] = {10'd0,   10'd24,  {5{10'd6}},                          1'b0};
      vecs[5] = {10'd2,   10'd24,  {10'd129, 10'd6, 10'd6, 10'd6, 10'd6}, 1'b0};
      vecs[6] = {10'd2,   10'd24,  {10'd1, 10'd2, 10'd3, 10'd4, 10'd7}, 1'b1};

      exp_idiv  = 10'd2;
      exp_fdiv  = 10'd24;
      exp_odiv  = {5{10'd6}};
      pll_rst   = 1'b1;
      lock_raw  = 1'b0;
      cfg_valid = 1'b0;
      cfg_idiv  = 10'd0;
      cfg_fdiv  = 10'd0;
      cfg_odiv  = '0;
      repeat (3) cyc();

      // Reset values
      chk("rst prim_rst", 64'(prim_rst), 64'd1);
      chk("rst pll_lock", 64'(pll_lock), 64'd0);
      chk("rst cfg_ready", 64'(cfg_ready), 64'd0);
      chk("rst cfg_err", 64'(cfg_err), 64'd0);
      chk("rst busy", 64'(busy), 64'd1);
      chk("rst fail", 64'(fail), 64'd0);
      chk("rst lost", 64'(lock_lost_cnt), 64'd0);
      chk("rst dyn_idiv", 64'(dyn_idiv), 64'(exp_idiv));
      chk("rst dyn_fdiv", 64'(dyn_fdiv), 64'(exp_fdiv));
      chk("rst dyn_odiv", 64'(dyn_odiv), 64'(exp_odiv));
      chk("rst dyn_duty", 64'(dyn_duty), 64'(exp_odiv));

      // Release; lock_raw rises 40 cycles later
      pll_rst = 1'b0;
      count_high(n);
      chk("init hold len", 64'(n), 64'd16);
      repeat (24) cyc();
      chk("wait prim_rst", 64'(prim_rst), 64'd0);
      chk("wait busy", 64'(busy), 64'd1);
      chk("wait pll_lock", 64'(pll_lock), 64'd0);
      lock_raw = 1'b1;
      wait_lock(n);
      chk("init lock latency", 64'(n), 64'd258);
      chk("locked busy", 64'(busy), 64'd0);
      chk("locked cfg_ready", 64'(cfg_ready), 64'd1);
      chk("locked dyn_odiv", 64'(dyn_odiv), 64'(exp_odiv));

      // One-cycle lock glitch
      lock_raw = 1'b0;
      cyc();
      lock_raw = 1'b1;
      chk("glitch lock e1", 64'(pll_lock), 64'd1);
      cyc();
      chk("glitch lock e2", 64'(pll_lock), 64'd1);
      cyc();
      chk("glitch lock e3", 64'(pll_lock), 64'd0);
      chk("glitch prim_rst", 64'(prim_rst), 64'd1);
      chk("glitch lost", 64'(lock_lost_cnt), 64'd1);
      count_high(n);
      chk("glitch hold len", 64'(n), 64'd16);
      wait_lock(n);
      chk("glitch relock", 64'(n), 64'd256);

      // Configuration vector table, applied while LOCKED
      for (int i = 0; i < 7; i++) begin
         offer(vecs[i].idiv, vecs[i].fdiv, vecs[i].odiv);
         if (vecs[i].ok) begin
            exp_idiv = vecs[i].idiv;
            exp_fdiv = vecs[i].fdiv;
            exp_odiv = vecs[i].odiv;
         end
         chk($sformatf("vec%0d cfg_err", i), 64'(cfg_err), 64'(!vecs[i].ok));
         chk($sformatf("vec%0d prim_rst", i), 64'(prim_rst), 64'(vecs[i].ok));
         chk($sformatf("vec%0d pll_lock", i), 64'(pll_lock), 64'(!vecs[i].ok));
         chk($sformatf("vec%0d cfg_ready", i), 64'(cfg_ready), 64'(!vecs[i].ok));
         chk($sformatf("vec%0d dyn_idiv", i), 64'(dyn_idiv), 64'(exp_idiv));
         chk($sformatf("vec%0d dyn_fdiv", i), 64'(dyn_fdiv), 64'(exp_fdiv));
         chk($sformatf("vec%0d dyn_odiv", i), 64'(dyn_odiv), 64'(exp_odiv));
         chk($sformatf("vec%0d dyn_duty", i), 64'(dyn_duty), 64'(exp_odiv));
         if (vecs[i].ok) begin
            count_high(n);
            chk($sformatf("vec%0d hold len", i), 64'(n), 64'd16);
            wait_lock(n);
            chk($sformatf("vec%0d relock", i), 64'(n), 64'd256);
         end else begin
            cyc();
            chk($sformatf("vec%0d err pulse", i), 64'(cfg_err), 64'd0);
         end
      end

      // Configuration and lock loss on the same edge: configuration wins
      lock_raw = 1'b0;
      cyc();
      cyc();
      exp_idiv = 10'd3;
      exp_fdiv = 10'd40;
      exp_odiv = {5{10'd9}};
      offer(exp_idiv, exp_fdiv, exp_odiv);
      lock_raw = 1'b1;
      chk("race dyn_idiv", 64'(dyn_idiv), 64'(exp_idiv));
      chk("race dyn_odiv", 64'(dyn_odiv), 64'(exp_odiv));
      chk("race lost", 64'(lock_lost_cnt), 64'd2);
      chk("race prim_rst", 64'(prim_rst), 64'd1);
      chk("race pll_lock", 64'(pll_lock), 64'd0);
      count_high(n);
      chk("race hold len", 64'(n), 64'd16);
      wait_lock(n);
      chk("race relock", 64'(n), 64'd256);

      // Permanent lock loss: three attempts then FAILED
      lock_raw = 1'b0;
      repeat (3) cyc();
      chk("loss pll_lock", 64'(pll_lock), 64'd0);
      chk("loss lost", 64'(lock_lost_cnt), 64'd3);
      for (int p = 0; p < 3; p++) begin
         count_high(n);
         chk($sformatf("retry%0d hold len", p), 64'(n), 64'd16);
         count_low(n);
         chk($sformatf("retry%0d wait len", p), 64'(n), 64'd100);
      end
      chk("failed fail", 64'(fail), 64'd1);
      chk("failed busy", 64'(busy), 64'd0);
      chk("failed cfg_ready", 64'(cfg_ready), 64'd1);
      chk("failed prim_rst", 64'(prim_rst), 64'd1);
      repeat (20) cyc();
      chk("failed sticky", 64'(fail), 64'd1);

      // Recovery from FAILED through configuration
      offer(10'd4, 10'd0, {5{10'd8}});
      chk("failed bad cfg_err", 64'(cfg_err), 64'd1);
      chk("failed bad fail", 64'(fail), 64'd1);
      chk("failed bad dyn_fdiv", 64'(dyn_fdiv), 64'(exp_fdiv));
      cyc();
      chk("failed bad pulse", 64'(cfg_err), 64'd0);
      exp_idiv = 10'd4;
      exp_fdiv = 10'd50;
      exp_odiv = {5{10'd8}};
      offer(exp_idiv, exp_fdiv, exp_odiv);
      chk("recover fail", 64'(fail), 64'd0);
      chk("recover busy", 64'(busy), 64'd1);
      chk("recover prim_rst", 64'(prim_rst), 64'd1);
      chk("recover dyn_fdiv", 64'(dyn_fdiv), 64'(exp_fdiv));
      lock_raw = 1'b1;
      count_high(n);
      chk("recover hold len", 64'(n), 64'd16);
      wait_lock(n);
      chk("recover relock", 64'(n), 64'd256);
      chk("recover lost", 64'(lock_lost_cnt), 64'd3);

      // Asynchronous reset mid-operation
      #2;
      pll_rst = 1'b1;
      #1;
      chk("arst prim_rst", 64'(prim_rst), 64'd1);
      chk("arst pll_lock", 64'(pll_lock), 64'd0);
      chk("arst cfg_ready", 64'(cfg_ready), 64'd0);
      chk("arst busy", 64'(busy), 64'd1);
      chk("arst lost", 64'(lock_lost_cnt), 64'd0);
      chk("arst dyn_idiv", 64'(dyn_idiv), 64'd2);
      chk("arst dyn_fdiv", 64'(dyn_fdiv), 64'd24);
      chk("arst dyn_odiv", 64'(dyn_odiv), 64'({5{10'd6}}));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
